vx_mem_responder: RTL and testbench

- Line-granular memory slave: the responder end of the cache memory-side bus. Accepts line read/write requests with tags, returns read data with the original tag.
- Sits below a cache or bypass unit as a synthesizable memory model for cluster-level simulation and FPGA bring-up without external DRAM.
- Backing store is an internal line-wide array, with a fixed-latency read pipeline and a credit-limited in-order response queue.

---
 rtl/vx_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_vx_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// Line-granular memory slave with a fixed-latency read pipeline and a credit-limited in-order response queue.
// Define VX_MEM_RESPONDER_PERF_EN to add saturating perf_reads/perf_writes/perf_stalls counter outputs.
module vx_mem_responder #(
  parameter int LINE_SIZE  = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8,
  parameter int LATENCY    = 4,
  parameter int RSQ_SIZE   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LINE_SIZE-1:0]    req_byteen,
  input  logic [LINE_SIZE*8-1:0]  req_data,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [LINE_SIZE*8-1:0]  rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  input  logic                    rsp_ready
`ifdef VX_MEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int DATA_WIDTH = LINE_SIZE * 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CNT_W      = $clog2(RSQ_SIZE) + 1;
  localparam int IDX_W      = $clog2(RSQ_SIZE);
  localparam logic [CNT_W-1:0] RSQ_LIMIT = CNT_W'(RSQ_SIZE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_line;
  logic [CNT_W-1:0]      outstanding;
  logic                  req_fire;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rsp_fire;

  logic                  push_valid;
  logic [TAG_WIDTH-1:0]  push_tag;
  logic [DATA_WIDTH-1:0] push_data;

  logic [TAG_WIDTH-1:0]  q_tag  [RSQ_SIZE];
  logic [DATA_WIDTH-1:0] q_data [RSQ_SIZE];
  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;

  // Ready depends only on the credit count (and reset), never on rsp_ready or req_valid.
  assign req_ready = !reset && (outstanding < RSQ_LIMIT);
  assign req_fire  = req_valid && req_ready;
  assign rd_accept = req_fire && !req_rw;
  assign wr_accept = req_fire && req_rw;

  assign rd_line = mem[req_addr];

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        if (req_byteen[i]) begin
          mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_accept, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // The response queue register is the last latency stage, so the shift register holds LATENCY-1 stages.
  generate
    if (LATENCY <= 1) begin : g_no_pipe
      assign push_valid = rd_accept;
      assign push_tag   = req_tag;
      assign push_data  = rd_line;
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic                  stg_valid [STAGES];
      logic [TAG_WIDTH-1:0]  stg_tag   [STAGES];
      logic [DATA_WIDTH-1:0] stg_data  [STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) begin
            stg_valid[i] <= 1'b0;
          end
        end else begin
          stg_valid[0] <= rd_accept;
          for (int i = 1; i < STAGES; i++) begin
            stg_valid[i] <= stg_valid[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rd_accept) begin
          stg_tag[0]  <= req_tag;
          stg_data[0] <= rd_line;
        end
        for (int i = 1; i < STAGES; i++) begin
          stg_tag[i]  <= stg_tag[i-1];
          stg_data[i] <= stg_data[i-1];
        end
      end

      assign push_valid = stg_valid[STAGES-1];
      assign push_tag   = stg_tag[STAGES-1];
      assign push_data  = stg_data[STAGES-1];
    end
  endgenerate

  // Credits cap in-flight reads at RSQ_SIZE, so the queue never needs a full check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_valid) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (rsp_fire) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) begin
      q_tag[wr_ptr[IDX_W-1:0]]  <= push_tag;
      q_data[wr_ptr[IDX_W-1:0]] <= push_data;
    end
  end

  assign rsp_valid = (wr_ptr != rd_ptr);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? q_data[rd_ptr[IDX_W-1:0]] : '0;
  assign rsp_tag   = rsp_valid ? q_tag[rd_ptr[IDX_W-1:0]]  : '0;

`ifdef VX_MEM_RESPONDER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (rd_accept && (perf_reads != 32'hFFFF_FFFF)) begin
        perf_reads <= perf_reads + 32'd1;
      end
      if (wr_accept && (perf_writes != 32'hFFFF_FFFF)) begin
        perf_writes <= perf_writes + 32'd1;
      end
      if (req_valid && !req_ready && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed self-checking bench for vx_mem_responder: latency, byte enables, credits, ordering, reset drop.
// Perf counter checks are compiled in when VX_MEM_RESPONDER_PERF_EN is defined.
module tb_vx_mem_responder;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_rw;
  logic [9:0]    req_addr;
  logic [63:0]   req_byteen;
  logic [DW-1:0] req_data;
  logic [7:0]    req_tag;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [7:0]    rsp_tag;
  logic          rsp_ready;
`ifdef VX_MEM_RESPONDER_PERF_EN
  logic [31:0]   perf_reads;
  logic [31:0]   perf_writes;
  logic [31:0]   perf_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  vx_mem_responder #(
    .LINE_SIZE(64), .ADDR_WIDTH(10), .TAG_WIDTH(8), .LATENCY(4), .RSQ_SIZE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_rw(req_rw),
    .req_addr(req_addr),
    .req_byteen(req_byteen),
    .req_data(req_data),
    .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready)
`ifdef VX_MEM_RESPONDER_PERF_EN
    ,
    .perf_reads(perf_reads),
    .perf_writes(perf_writes),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic rw, input logic [9:0] addr,
                               input logic [63:0] byteen, input logic [DW-1:0] data, input logic [7:0] tag);
    req_valid  = valid;
    req_rw     = rw;
    req_addr   = addr;
    req_byteen = byteen;
    req_data   = data;
    req_tag    = tag;
  endtask

  // Presents a request, waits (bounded) for ready, lets it be accepted, then drops valid.
  task automatic issueRequest(input logic rw, input logic [9:0] addr, input logic [63:0] byteen,
                              input logic [DW-1:0] data, input logic [7:0] tag);
    int n;
    applyStimulus(1'b1, rw, addr, byteen, data, tag);
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) checkOutput("accept_timeout", DW'(req_ready), DW'(1'b1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!rsp_valid) checkOutput({name, "_timeout"}, DW'(rsp_valid), DW'(1'b1));
  endtask

  task automatic readAndCheck(input logic [9:0] addr, input logic [7:0] tag, input logic [DW-1:0] expected, input string name);
    issueRequest(1'b0, addr, '0, '0, tag);
    waitRsp(name);
    checkOutput({name, "_data"}, rsp_data, expected);
    checkOutput({name, "_tag"}, DW'(rsp_tag), DW'(tag));
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int cnt;
    logic [DW-1:0] ones11;
    logic [DW-1:0] partial;
    ones11  = {64{8'h11}};
    partial = {{63{8'h11}}, 8'h99};

    reset = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (3) tick();
    checkOutput("rst_req_ready", DW'(req_ready), DW'(1'b0));
    checkOutput("rst_rsp_valid", DW'(rsp_valid), DW'(1'b0));
    checkOutput("rst_rsp_data", rsp_data, '0);
    checkOutput("rst_rsp_tag", DW'(rsp_tag), DW'(8'h00));
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", DW'(req_ready), DW'(1'b1));

    // Full write then read: first response exactly 4 edges after accept.
    rsp_ready = 1'b1;
    issueRequest(1'b1, 10'h005, '1, ones11, 8'h00);
    applyStimulus(1'b1, 1'b0, 10'h005, '0, '0, 8'h3A);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("read_latency", DW'(lat), DW'(4));
    checkOutput("read_data", rsp_data, ones11);
    checkOutput("read_tag", DW'(rsp_tag), DW'(8'h3A));
    tick();
    checkOutput("rsp_drained", DW'(rsp_valid), DW'(1'b0));

    issueRequest(1'b1, 10'h005, 64'h1, {{63{8'hEE}}, 8'h99}, 8'h00);
    readAndCheck(10'h005, 8'h3B, partial, "partial");

    // Credit exhaustion and in-order drain.
    for (int i = 1; i <= 4; i++) issueRequest(1'b1, 10'(32'h1F + i), '1, {64{8'(i)}}, 8'h00);
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issueRequest(1'b0, 10'(32'h1F + i), '0, '0, 8'(i));
    checkOutput("credit_full_ready", DW'(req_ready), DW'(1'b0));
    applyStimulus(1'b1, 1'b0, 10'h005, '0, '0, 8'h05);
    repeat (5) tick();
    checkOutput("fifth_held", DW'(req_ready), DW'(1'b0));
    checkOutput("head_tag1", DW'(rsp_tag), DW'(8'h01));
    checkOutput("head_data1", rsp_data, {64{8'h01}});
    rsp_ready = 1'b1;
    tick();
    checkOutput("ready_after_fire", DW'(req_ready), DW'(1'b1));
    checkOutput("order_tag2", DW'(rsp_tag), DW'(8'h02));
    tick();
    req_valid = 1'b0;
    checkOutput("order_tag3", DW'(rsp_tag), DW'(8'h03));
    tick();
    checkOutput("order_tag4", DW'(rsp_tag), DW'(8'h04));
    checkOutput("order_data4", rsp_data, {64{8'h04}});
    tick();
    waitRsp("fifth");
    checkOutput("fifth_tag", DW'(rsp_tag), DW'(8'h05));
    checkOutput("fifth_data", rsp_data, partial);
    tick();

    // Write accepted after an in-flight read must not change that read's data.
    issueRequest(1'b1, 10'h010, '1, {64{8'hA5}}, 8'h00);
    applyStimulus(1'b1, 1'b0, 10'h010, '0, '0, 8'h07);
    tick();
    applyStimulus(1'b1, 1'b1, 10'h010, '1, {64{8'h5A}}, 8'h00);
    tick();
    req_valid = 1'b0;
    waitRsp("raw");
    checkOutput("raw_data", rsp_data, {64{8'hA5}});
    checkOutput("raw_tag", DW'(rsp_tag), DW'(8'h07));
    tick();
    readAndCheck(10'h010, 8'h08, {64{8'h5A}}, "post_write");

    // Reset with one response queued and one read still in the pipeline.
    rsp_ready = 1'b0;
    issueRequest(1'b0, 10'h005, '0, '0, 8'h61);
    waitRsp("pre_reset");
    applyStimulus(1'b1, 1'b0, 10'h021, '0, '0, 8'h62);
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_valid", DW'(rsp_valid), DW'(1'b0));
    checkOutput("mid_rst_rsp_tag", DW'(rsp_tag), DW'(8'h00));
    checkOutput("mid_rst_req_ready", DW'(req_ready), DW'(1'b0));
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_release_ready", DW'(req_ready), DW'(1'b1));
    rsp_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      tick();
      if (rsp_valid) cnt++;
    end
    checkOutput("no_stale_rsp", DW'(cnt), DW'(0));

`ifdef VX_MEM_RESPONDER_PERF_EN
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issueRequest(1'b1, 10'(32'h40 + i), '1, {64{8'h33}}, 8'h00);
    for (int i = 0; i < 4; i++) issueRequest(1'b0, 10'(32'h40 + i), '0, '0, 8'(32'h70 + i));
    waitRsp("perf_fill");
    applyStimulus(1'b1, 1'b0, 10'h040, '0, '0, 8'h74);
    tick();
    rsp_ready = 1'b1;
    tick();
    checkOutput("perf_ready_back", DW'(req_ready), DW'(1'b1));
    tick();
    req_valid = 1'b0;
    repeat (12) tick();
    checkOutput("perf_writes", DW'(perf_writes), DW'(32'd3));
    checkOutput("perf_reads", DW'(perf_reads), DW'(32'd5));
    checkOutput("perf_stalls", DW'(perf_stalls), DW'(32'd2));
`endif

    readAndCheck(10'h005, 8'h44, partial, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
